// File: rtl/branch_seq.sv
// Branch-resolution stage: captures a branch and its PC, waits for R[ra], evaluates the
// CON condition, and issues a one-cycle PC load with saturating branch statistics.
module branch_seq #(
   parameter int unsigned CW   = 19,
   parameter int unsigned CNTW = 16
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [31:0]     ir,
   input  logic [31:0]     pc_in,
   input  logic            data_valid,
   input  logic [31:0]     bus_data,
   output logic            busy,
   output logic            con,
   output logic [31:0]     pc_next,
   output logic            pc_load,
   output logic            done,
   output logic [CNTW-1:0] branch_cnt,
   output logic [CNTW-1:0] taken_cnt
);

   typedef enum logic [1:0] {StIdle, StFetchRa, StEval, StCommit} state_e;

   state_e state_q, state_d;

   // Only the condition selector and displacement fields of IR are needed downstream.
   logic [20:0]     ir_q, ir_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     data_q, data_d;
   logic [31:0]     target_q, target_d;
   logic [31:0]     pc_next_q, pc_next_d;
   logic            con_q, con_d;
   logic            pc_load_q, pc_load_d;
   logic            done_q, done_d;
   logic [CNTW-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNTW-1:0] taken_cnt_q, taken_cnt_d;

   logic [31:0]     disp;
   logic            cond;
   logic            unused_ir;

   assign unused_ir = ^ir[31:21];

   assign disp = {{(32 - CW){ir_q[CW-1]}}, ir_q[CW-1:0]};

   always_comb begin
      cond = 1'b0;
      unique case (ir_q[20:19])
         2'b00: cond = (data_q == 32'd0);
         2'b01: cond = (data_q != 32'd0);
         2'b10: cond = ~data_q[31];
         2'b11: cond = data_q[31];
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      pc_d         = pc_q;
      data_d       = data_q;
      target_d     = target_q;
      pc_next_d    = pc_next_q;
      con_d        = con_q;
      pc_load_d    = 1'b0;
      done_d       = 1'b0;
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               ir_d    = ir[20:0];
               pc_d    = pc_in;
               state_d = StFetchRa;
            end
         end
         StFetchRa: begin
            if (data_valid) begin
               data_d  = bus_data;
               state_d = StEval;
            end
         end
         StEval: begin
            con_d    = cond;
            target_d = pc_q + disp;
            state_d  = StCommit;
         end
         StCommit: begin
            done_d    = 1'b1;
            pc_load_d = con_q;
            pc_next_d = con_q ? target_q : pc_q;
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNTW'(1);
            if (con_q && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNTW'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= StIdle;
         ir_q         <= '0;
         pc_q         <= '0;
         data_q       <= '0;
         target_q     <= '0;
         pc_next_q    <= '0;
         con_q        <= 1'b0;
         pc_load_q    <= 1'b0;
         done_q       <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         pc_q         <= pc_d;
         data_q       <= data_d;
         target_q     <= target_d;
         pc_next_q    <= pc_next_d;
         con_q        <= con_d;
         pc_load_q    <= pc_load_d;
         done_q       <= done_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign con        = con_q;
   assign pc_next    = pc_next_q;
   assign pc_load    = pc_load_q;
   assign done       = done_q;
   assign branch_cnt = branch_cnt_q;
   assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq: directed and random branches against a behavioural model.
// Counters are narrowed so saturation is reached in a short run.
module tb_branch_seq;

   localparam int unsigned TbCntw = 5;
   localparam int          MaxCnt = (1 << TbCntw) - 1;

   logic              clk = 1'b0;
   logic              clr, start, data_valid;
   logic [31:0]       ir, pc_in, bus_data, pc_next;
   logic              busy, con, pc_load, done;
   logic [TbCntw-1:0] branch_cnt, taken_cnt;

   int          errors = 0;
   int          checks = 0;
   int          m_br, m_tk;
   logic        m_con;
   logic [31:0] m_pc;

   branch_seq #(.CW(19), .CNTW(TbCntw)) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .ir         (ir),
      .pc_in      (pc_in),
      .data_valid (data_valid),
      .bus_data   (bus_data),
      .busy       (busy),
      .con        (con),
      .pc_next    (pc_next),
      .pc_load    (pc_load),
      .done       (done),
      .branch_cnt (branch_cnt),
      .taken_cnt  (taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Returns {taken, next_pc} from the branch semantics with signed arithmetic.
   function automatic logic [32:0] ref_branch(input logic [31:0] i_ir, input logic [31:0] i_pc,
                                              input logic [31:0] i_data);
      logic signed [31:0] d;
      logic               take;
      int                 kind;
      d    = $signed({i_ir[18:0], 13'd0}) >>> 13;
      kind = int'(i_ir[20:19]);
      case (kind)
         0:       take = (i_data == 32'd0);
         1:       take = (i_data != 32'd0);
         2:       take = ($signed(i_data) >= 0);
         default: take = ($signed(i_data) < 0);
      endcase
      return {take, take ? i_pc + 32'(d) : i_pc};
   endfunction

   task automatic do_branch(input logic [31:0] i_ir, input logic [31:0] i_pc,
                            input logic [31:0] i_data, input int stall,
                            input bit extra_start, input bit commit_start, input bit b2b);
      logic [32:0] r;
      r          = ref_branch(i_ir, i_pc, i_data);
      ir         = i_ir;
      pc_in      = i_pc;
      bus_data   = i_data;
      data_valid = (stall == 0);
      start      = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("done_fetch", 32'(done), 32'd0);
      for (int k = 0; k < stall; k++) begin
         data_valid = 1'b0;
         if (extra_start && k == 2) begin
            start = 1'b1;
            ir    = ~i_ir;
            pc_in = ~i_pc;
         end
         tick();
         start = 1'b0;
         chk("busy_stall", 32'(busy), 32'd1);
         chk("done_stall", 32'(done), 32'd0);
      end
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("busy_eval", 32'(busy), 32'd1);
      chk("done_eval", 32'(done), 32'd0);
      tick();
      chk("con_commit", 32'(con), 32'(r[32]));
      chk("done_commit", 32'(done), 32'd0);
      chk("busy_commit", 32'(busy), 32'd1);
      if (commit_start) begin
         start = 1'b1;
         ir    = ~i_ir;
      end
      m_br  = (m_br < MaxCnt) ? m_br + 1 : MaxCnt;
      if (r[32]) m_tk = (m_tk < MaxCnt) ? m_tk + 1 : MaxCnt;
      m_con = r[32];
      m_pc  = r[31:0];
      tick();
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("pc_load_pulse", 32'(pc_load), 32'(m_con));
      chk("pc_next", pc_next, m_pc);
      chk("busy_done", 32'(busy), 32'd0);
      chk("branch_cnt", 32'(branch_cnt), 32'(m_br));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tk));
      if (!b2b) begin
         tick();
         chk("done_width", 32'(done), 32'd0);
         chk("pc_load_width", 32'(pc_load), 32'd0);
         chk("con_hold", 32'(con), 32'(m_con));
         chk("pc_next_hold", pc_next, m_pc);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_con"}, 32'(con), 32'd0);
      chk({tag, "_pc_next"}, pc_next, 32'd0);
      chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'd0);
      chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'd0);
   endtask

   initial begin
      logic [31:0] rir, rpc, rdata;
      clr = 1'b1; start = 1'b0; data_valid = 1'b0;
      ir = '0; pc_in = '0; bus_data = '0;
      m_br = 0; m_tk = 0; m_con = 1'b0; m_pc = '0;
      tick();
      tick();
      clr = 1'b0;
      chk_reset_state("reset");

      // brzr taken
      do_branch({11'd0, 2'b00, 19'h00010}, 32'h0000_0020, 32'd0, 0, 1'b0, 1'b0, 1'b0);
      chk("brzr_con", 32'(con), 32'd1);
      chk("brzr_pc_next", pc_next, 32'h0000_0030);
      chk("brzr_cnts", {16'(branch_cnt), 16'(taken_cnt)}, {16'd1, 16'd1});

      // brnz not taken
      do_branch({11'd0, 2'b01, 19'h00010}, 32'h0000_0005, 32'd0, 0, 1'b0, 1'b0, 1'b0);
      chk("brnz_con", 32'(con), 32'd0);
      chk("brnz_pc_next", pc_next, 32'h0000_0005);
      chk("brnz_taken_cnt", 32'(taken_cnt), 32'd1);

      // brmi with wrap; a start during COMMIT is dropped, next branch issued back-to-back
      do_branch({11'd0, 2'b11, 19'h7FFFC}, 32'h0000_0002, 32'h8000_0000, 0, 1'b0, 1'b1, 1'b1);
      chk("brmi_pc_next", pc_next, 32'hFFFF_FFFE);
      do_branch({11'd0, 2'b10, 19'h7FFFC}, 32'h0000_0010, 32'h7FFF_FFFF, 0, 1'b0, 1'b0, 1'b0);
      chk("brpl_pc_next", pc_next, 32'h0000_000C);

      // stalled operand with a dropped start mid-stall
      do_branch({11'd0, 2'b00, 19'h00100}, 32'h0000_1000, 32'd0, 5, 1'b1, 1'b0, 1'b0);
      chk("stall_pc_next", pc_next, 32'h0000_1100);
      chk("stall_branch_cnt", 32'(branch_cnt), 32'd5);

      // clr while in EVAL aborts the branch
      ir = {11'd0, 2'b00, 19'h00004}; pc_in = 32'h40; bus_data = 32'd0;
      data_valid = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("abort_busy_eval", 32'(busy), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0; data_valid = 1'b0;
      m_br = 0; m_tk = 0; m_con = 1'b0; m_pc = '0;
      chk_reset_state("abort");
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("abort_no_done", {31'd0, done}, 32'd0);
         chk("abort_no_pc_load", {31'd0, pc_load}, 32'd0);
      end

      // random branches; counters cross saturation along the way
      for (int n = 0; n < 40; n++) begin
         rir = $urandom;
         rpc = $urandom;
         case ($urandom_range(0, 3))
            0:       rdata = 32'd0;
            1:       rdata = 32'h8000_0000 | $urandom;
            default: rdata = $urandom;
         endcase
         do_branch(rir, rpc, rdata, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
      end
      for (int n = 0; n < MaxCnt + 2; n++) begin
         rir = {$urandom} & 32'hFFE7_FFFF | 32'h0008_0000;
         do_branch(rir, $urandom, 32'h1 | $urandom, 0, 1'b0, 1'b0, 1'b0);
      end
      chk("sat_branch_cnt", 32'(branch_cnt), 32'(MaxCnt));
      chk("sat_taken_cnt", 32'(taken_cnt), 32'(MaxCnt));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
